load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_load_align.sv | 32 +++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding, access-size codes
// and the byte-lane helpers used on the store path.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // funct3[1:0] = 11 is treated as a word access
    function automatic logic [1:0] decode_size(input logic [1:0] f);
        case (f)
            2'b00:   decode_size = SIZE_B;
            2'b01:   decode_size = SIZE_H;
            default: decode_size = SIZE_W;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_B:  byte_enables = 4'b0001 << lo;
            SIZE_H:  byte_enables = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SIZE_B:  replicate = {4{d[7:0]}};
            SIZE_H:  replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a bus read word and sign- or
// zero-extends it to 32 bits. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] value
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (addr_lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // halfword lane follows addr[1] only; addr[0] never reaches here as a selector
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  value = {{24{b[7] & ~uns}}, b};
            SIZE_H:  value = {{16{h[15] & ~uns}}, h};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> BUS -> DONE sequencer with bus timeout.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  state_dbg
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e  state;
    logic [CW-1:0] cnt;
    logic        op_we;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_in;
    logic        req;
    logic        mis_req;
    logic [31:0] load_val;

    assign size_in   = decode_size(funct3[1:0]);
    assign req       = mem_read_en | mem_write_en;
    assign state_dbg = state;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_req = ((size_in == SIZE_H) && addr[0]) ||
                     ((size_in == SIZE_W) && (addr[1:0] != 2'b00));
`else
    assign mis_req = 1'b0;
`endif

    // Bus handshake: bus_req is held with address/data/strobes stable until the
    // cycle bus_ack is seen high; ack in any other cycle carries no meaning.
    assign stall = ~rst & (((state == IDLE) & req) | (state == BUS));

    lsu_load_align u_align (
        .word    (bus_rdata),
        .addr_lo (addr_lo_q),
        .size    (size_q),
        .uns     (uns_q),
        .value   (load_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_we      <= 1'b0;
            size_q     <= SIZE_W;
            uns_q      <= 1'b0;
            addr_lo_q  <= 2'b00;
            rdata      <= '0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
        end else begin
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_we     <= mem_write_en;
                        size_q    <= size_in;
                        uns_q     <= funct3[2];
                        addr_lo_q <= addr[1:0];
                        cnt       <= '0;
                        if (mis_req) begin
                            state    <= DONE;
                            misalign <= 1'b1;
                        end else begin
                            state     <= BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write_en;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= replicate(size_in, wdata);
                            bus_be    <= byte_enables(size_in, addr[1:0]);
                        end
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_be  <= '0;
                        if (!op_we) begin
                            rdata      <= load_val;
                            load_valid <= 1'b1;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        bus_err <= 1'b1;
                        rdata   <= '0;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_be  <= '0;
                        cnt     <= cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads/stores of every size, timeout,
// ack outside a transaction, reset mid-transaction, misaligned accesses.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_en = 1'b0;
    logic        mem_write_en = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        load_valid;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [1:0]  state_dbg;

    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    int          n_checks = 0;
    int          n_pass = 0;
    int          bus_cycles;

    load_store_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .load_valid(load_valid),
        .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access: request in IDLE, ack after 'delay' waiting BUS cycles.
    task automatic access(input string tag, input logic re, input logic we,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] brd, input int delay, input logic [3:0] exp_be,
                          input logic [31:0] exp_bwd, input logic [31:0] exp_rd);
        mem_read_en = re; mem_write_en = we; funct3 = f3; addr = a; wdata = wd;
        if (re && !we) begin
            exp_q.push_back(exp_rd);
            last_rd = exp_rd;
        end
        @(negedge clk);
        check({tag, "_stall_idle"}, stall, 1);
        tick();
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        for (int i = 0; i < delay; i++) tick();
        bus_ack = 1'b1; bus_rdata = brd;
        @(negedge clk);
        check({tag, "_bus_req"}, bus_req, 1);
        check({tag, "_bus_we"}, bus_we, we);
        check({tag, "_bus_be"}, bus_be, exp_be);
        check({tag, "_bus_addr"}, bus_addr, {a[31:2], 2'b00});
        check({tag, "_stall_bus"}, stall, 1);
        if (we) check({tag, "_bus_wdata"}, bus_wdata, exp_bwd);
        tick();
        bus_ack = 1'b0; bus_rdata = 32'hA5A5_5A5A;
        @(negedge clk);
        check({tag, "_load_valid"}, load_valid, re && !we);
        check({tag, "_stall_done"}, stall, 0);
        check({tag, "_misalign"}, misalign, 0);
        check({tag, "_state_done"}, state_dbg, DONE);
        if (load_valid) begin
            if (exp_q.size() == 0) check({tag, "_unexpected_load"}, 1, 0);
            else check({tag, "_rdata"}, rdata, exp_q.pop_front());
        end
        tick();
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic trap_access(input string tag, input logic [2:0] f3, input logic [31:0] a);
        mem_read_en = 1'b1; funct3 = f3; addr = a;
        @(negedge clk);
        check({tag, "_stall_idle"}, stall, 1);
        tick();
        mem_read_en = 1'b0;
        @(negedge clk);
        check({tag, "_no_bus_req"}, bus_req, 0);
        check({tag, "_misalign"}, misalign, 1);
        check({tag, "_load_valid"}, load_valid, 0);
        check({tag, "_rdata_hold"}, rdata, last_rd);
        check({tag, "_state_done"}, state_dbg, DONE);
        tick();
        @(negedge clk);
        check({tag, "_misalign_pulse"}, misalign, 0);
        tick();
    endtask
`endif

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", state_dbg, IDLE);
        check("rst_stall", stall, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_load_valid", load_valid, 0);
        check("rst_bus_err", bus_err, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", state_dbg, IDLE);
        tick();

        // loads
        access("lb",  1, 0, 3'b000, 32'h0000_0103, 0, 32'h80FF_FFFF, 0, 4'b1000, 0, 32'hFFFF_FF80);
        access("lhu", 1, 0, 3'b101, 32'h0000_0102, 0, 32'hBEEF_1234, 0, 4'b1100, 0, 32'h0000_BEEF);
        access("lh",  1, 0, 3'b001, 32'h0000_0100, 0, 32'h1234_8001, 1, 4'b0011, 0, 32'hFFFF_8001);
        access("lbu", 1, 0, 3'b100, 32'h0000_0101, 0, 32'h0000_9A00, 0, 4'b0010, 0, 32'h0000_009A);
        access("lw",  1, 0, 3'b010, 32'h0000_0104, 0, 32'hDEAD_BEEF, 2, 4'b1111, 0, 32'hDEAD_BEEF);

        // misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        trap_access("lw_mis", 3'b010, 32'h0000_0302);
        trap_access("lh_mis", 3'b001, 32'h0000_0103);
`else
        access("lw_mis", 1, 0, 3'b010, 32'h0000_0302, 0, 32'hCAFE_F00D, 0, 4'b1111, 0, 32'hCAFE_F00D);
        access("lh_mis", 1, 0, 3'b001, 32'h0000_0103, 0, 32'hF00D_0000, 0, 4'b1100, 0, 32'hFFFF_F00D);
`endif

        // stores
        access("sb", 0, 1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 0, 0, 4'b0010, 32'hA5A5_A5A5, 0);
        access("sh", 0, 1, 3'b001, 32'h0000_0202, 32'h1234_CAFE, 0, 0, 4'b1100, 32'hCAFE_CAFE, 0);
        access("sw", 0, 1, 3'b010, 32'h0000_0300, 32'h1234_5678, 0, 3, 4'b1111, 32'h1234_5678, 0);
        access("rw_both", 1, 1, 3'b010, 32'h0000_0400, 32'h0BAD_F00D, 32'h7777_7777, 0, 4'b1111, 32'h0BAD_F00D, 0);
        check("store_rdata_hold", rdata, last_rd);

        // ack with no transaction in flight
        bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        check("stray_ack_req", bus_req, 0);
        tick();
        @(negedge clk);
        check("stray_ack_state", state_dbg, IDLE);
        check("stray_ack_lv", load_valid, 0);
        check("stray_ack_rdata", rdata, last_rd);
        tick();
        bus_ack = 1'b0;

        // timeout
        mem_read_en = 1'b1; funct3 = 3'b010; addr = 32'h0000_0500;
        tick();
        mem_read_en = 1'b0;
        bus_cycles = 0;
        @(negedge clk);
        while (bus_req && bus_cycles < 40) begin
            bus_cycles++;
            @(negedge clk);
        end
        check("to_bus_cycles", bus_cycles, 15);
        check("to_bus_err", bus_err, 1);
        check("to_rdata", rdata, 0);
        check("to_stall", stall, 0);
        check("to_load_valid", load_valid, 0);
        tick();
        @(negedge clk);
        check("to_err_pulse", bus_err, 0);
        check("to_state_idle", state_dbg, IDLE);
        tick();

        // reset in the second BUS cycle, late ack afterwards
        access("lw_pre", 1, 0, 3'b010, 32'h0000_0604, 0, 32'h2468_ACE0, 0, 4'b1111, 0, 32'h2468_ACE0);
        mem_read_en = 1'b1; funct3 = 3'b010; addr = 32'h0000_0600;
        tick();
        mem_read_en = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rstbus_req_before", bus_req, 1);
        tick();
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        @(negedge clk);
        check("rstbus_req_drop", bus_req, 0);
        check("rstbus_state", state_dbg, IDLE);
        check("rstbus_rdata", rdata, 0);
        check("rstbus_lv", load_valid, 0);
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        check("rstbus_late_lv", load_valid, 0);
        check("rstbus_late_rdata", rdata, 0);
        tick();

        // final report
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
